interface_jogada: RTL and testbench

Player-input front end for the memory game: the producer of the `jogada`/`timeout` handshake consumed by the game control unit while it waits for a move. When armed, it waits for all buttons to be released, then debounces a single-button press. It emits a one-cycle `jogada` pulse with the registered one-hot button code, or raises `timeout` if no valid press completes in time. Sits between the raw `botoes` pins and the datapath/control unit.

---
 rtl/jogada_pkg.sv | 22 ++
 rtl/interface_jogada_contador_limite.sv | 26 ++
 rtl/interface_jogada.sv | 105 ++++++++++
 tb/tb_interface_jogada.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jogada_pkg.sv
// Shared definitions for the player-input front end of the memory game:
// state codes, default timing parameters and the one-hot check.
package jogada_pkg;

   localparam int DEBOUNCE_PADRAO = 10;
   localparam int TIMEOUT_PADRAO  = 5000;

   typedef enum logic [3:0] {
      OCIOSO         = 4'd0,
      AGUARDA_SOLTA  = 4'd1,
      ARMADO         = 4'd2,
      FILTRA         = 4'd3,
      EMITE          = 4'd4,
      DESARMA        = 4'd5,
      TEMPO_ESGOTADO = 4'd6
   } estado_t;

   function automatic logic um_bit(input logic [3:0] v);
      return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
   endfunction

endpackage

// File: rtl/interface_jogada_contador_limite.sv
// Counter with synchronous clear and enable; fim flags the value LIMITE-1.
// Used for the debounce counter and the move timeout timer.
module contador_limite #(
   parameter int LIMITE  = 10,
   parameter int LARGURA = $clog2(LIMITE) + 1
) (
   input  logic clock,
   input  logic reset,
   input  logic zera,
   input  logic conta,
   output logic fim
);

   logic [LARGURA-1:0] valor;

   always_ff @(posedge clock) begin
      if (reset || zera) begin
         valor <= '0;
      end else if (conta) begin
         valor <= valor + 1'b1;
      end
   end

   assign fim = (valor == LARGURA'(LIMITE - 1));

endmodule

// File: rtl/interface_jogada.sv
// Player-input front end: release wait, single-button debounce, jogada pulse.
// Define INTERFACE_JOGADA_TIMEOUT_EN to build the move timeout timer.
module interface_jogada
   import jogada_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_PADRAO,
   parameter int TIMEOUT_CYCLES  = TIMEOUT_PADRAO
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       armar,
   input  logic [3:0] botoes,
   output logic       jogada,
   output logic [3:0] jogada_code,
   output logic       timeout,
   output logic [3:0] db_estado
);

   estado_t    estado;
   logic [3:0] candidato;
   logic       bate;
   logic       db_fim;
   logic       tempo_fim;

   assign bate      = (botoes == candidato);
   assign db_estado = estado;

   contador_limite #(
      .LIMITE  (DEBOUNCE_CYCLES),
      .LARGURA ($clog2(DEBOUNCE_CYCLES) + 1)
   ) u_debounce (
      .clock (clock),
      .reset (reset),
      .zera  ((estado != FILTRA) || !bate || !armar),
      .conta ((estado == FILTRA) && bate),
      .fim   (db_fim)
   );

`ifdef INTERFACE_JOGADA_TIMEOUT_EN
   contador_limite #(
      .LIMITE  (TIMEOUT_CYCLES),
      .LARGURA ($clog2(TIMEOUT_CYCLES))
   ) u_tempo (
      .clock (clock),
      .reset (reset),
      .zera  (estado == OCIOSO),
      .conta ((estado == AGUARDA_SOLTA) ||
              (estado == ARMADO) ||
              (estado == FILTRA)),
      .fim   (tempo_fim)
   );

   assign timeout = (estado == TEMPO_ESGOTADO);
`else
   assign tempo_fim = 1'b0;
   assign timeout   = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         estado      <= OCIOSO;
         candidato   <= 4'b0000;
         jogada      <= 1'b0;
         jogada_code <= 4'b0000;
      end else begin
         jogada <= 1'b0;
         unique case (estado)
            OCIOSO: begin
               if (armar) estado <= AGUARDA_SOLTA;
            end
            AGUARDA_SOLTA, ARMADO, FILTRA: begin
               // abort beats a finishing press, which beats the timer
               if (!armar) begin
                  estado <= OCIOSO;
               end else if (estado == FILTRA && bate && db_fim) begin
                  estado      <= EMITE;
                  jogada      <= 1'b1;
                  jogada_code <= candidato;
               end else if (tempo_fim) begin
                  estado <= TEMPO_ESGOTADO;
               end else if (estado == AGUARDA_SOLTA) begin
                  if (botoes == 4'b0000) estado <= ARMADO;
               end else if (estado == ARMADO) begin
                  if (um_bit(botoes)) begin
                     candidato <= botoes;
                     estado    <= FILTRA;
                  end
               end else if (!bate) begin
                  estado <= ARMADO;
               end
            end
            EMITE: begin
               estado <= DESARMA;
            end
            DESARMA, TEMPO_ESGOTADO: begin
               if (!armar) estado <= OCIOSO;
            end
            default: begin
               estado <= OCIOSO;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_interface_jogada.sv
// Bench for interface_jogada: directed vector table, reset/timeout
// sequences and a randomized run against a session-level model.
module tb_interface_jogada;

   localparam int DB = 4;
   localparam int TO = 20;
`ifdef INTERFACE_JOGADA_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clock;
   logic       reset;
   logic       armar;
   logic [3:0] botoes;
   logic       jogada;
   logic [3:0] jogada_code;
   logic       timeout;
   logic [3:0] db_estado;

   interface_jogada #(
      .DEBOUNCE_CYCLES (DB),
      .TIMEOUT_CYCLES  (TO)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .armar       (armar),
      .botoes      (botoes),
      .jogada      (jogada),
      .jogada_code (jogada_code),
      .timeout     (timeout),
      .db_estado   (db_estado)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;

   // session-level model of one arming period
   bit         m_sess, m_rel, m_jog, m_done, m_to;
   logic [3:0] m_cand, m_code;
   int         m_run, m_age;

   task automatic model_reset();
      m_sess = 0; m_rel = 0; m_jog = 0; m_done = 0; m_to = 0;
      m_cand = 4'b0; m_code = 4'b0; m_run = 0; m_age = 0;
   endtask

   task automatic model_edge();
      if (reset) begin
         model_reset();
      end else if (!m_sess) begin
         if (armar) begin
            m_sess = 1; m_rel = 0; m_jog = 0; m_done = 0; m_to = 0;
            m_cand = 4'b0; m_run = 0; m_age = 0;
         end
      end else if (m_jog) begin
         m_jog = 0;
      end else if (m_done || m_to) begin
         if (!armar) begin
            m_sess = 0; m_to = 0;
         end
      end else if (!armar) begin
         m_sess = 0;
      end else begin
         if (m_cand != 0 && botoes == m_cand && m_run == DB - 1) begin
            m_jog = 1; m_done = 1; m_code = m_cand;
         end else if (TO_EN && m_age == TO - 1) begin
            m_to = 1;
         end else if (!m_rel) begin
            m_rel = (botoes == 4'b0);
         end else if (m_cand == 0) begin
            if ($countones(botoes) == 1) begin
               m_cand = botoes; m_run = 0;
            end
         end else if (botoes == m_cand) begin
            m_run++;
         end else begin
            m_cand = 4'b0; m_run = 0;
         end
         m_age++;
      end
   endtask

   function automatic logic [3:0] m_estado();
      if (!m_sess)       return 4'd0;
      if (m_jog)         return 4'd4;
      if (m_done)        return 4'd5;
      if (m_to)          return 4'd6;
      if (!m_rel)        return 4'd1;
      if (m_cand == 0)   return 4'd2;
      return 4'd3;
   endfunction

   task automatic chk(input string nome, input logic [31:0] got,
                      input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nome, got, exp, $time);
      end
   endtask

   task automatic chk_model();
      chk("jogada", jogada, m_jog);
      chk("jogada_code", jogada_code, m_code);
      chk("timeout", timeout, m_to);
      chk("db_estado", db_estado, m_estado());
   endtask

   task automatic step(input logic a, input logic [3:0] b);
      armar  = a;
      botoes = b;
      @(posedge clock);
      model_edge();
      #1;
      chk_model();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(1'b0, 4'b0000);
      reset = 1'b0;
   endtask

   task automatic chk_reset_vals(input string nome);
      chk({nome, "_jogada"}, jogada, 1'b0);
      chk({nome, "_code"}, jogada_code, 4'b0000);
      chk({nome, "_timeout"}, timeout, 1'b0);
      chk({nome, "_estado"}, db_estado, 4'd0);
   endtask

   typedef struct {
      logic       a;
      logic [3:0] b;
      logic       j;
      logic [3:0] c;
      logic [3:0] e;
   } vec_t;

   vec_t tab[$];

   function automatic vec_t mk(logic a, logic [3:0] b, logic j,
                               logic [3:0] c, logic [3:0] e);
      vec_t v;
      v.a = a; v.b = b; v.j = j; v.c = c; v.e = e;
      return v;
   endfunction

   initial begin
      logic [3:0] rb;
      int hold;
      reset  = 1'b1;
      armar  = 1'b0;
      botoes = 4'b0000;
      model_reset();

      // clean press
      tab.push_back(mk(1, 4'h0, 0, 4'h0, 1));
      tab.push_back(mk(1, 4'h0, 0, 4'h0, 2));
      tab.push_back(mk(1, 4'h4, 0, 4'h0, 3));
      for (int i = 0; i < 3; i++) tab.push_back(mk(1, 4'h4, 0, 4'h0, 3));
      tab.push_back(mk(1, 4'h4, 1, 4'h4, 4));
      tab.push_back(mk(1, 4'h4, 0, 4'h4, 5));
      tab.push_back(mk(1, 4'h4, 0, 4'h4, 5));
      tab.push_back(mk(0, 4'h0, 0, 4'h4, 0));
      // bounce
      tab.push_back(mk(1, 4'h0, 0, 4'h4, 1));
      tab.push_back(mk(1, 4'h0, 0, 4'h4, 2));
      tab.push_back(mk(1, 4'h2, 0, 4'h4, 3));
      tab.push_back(mk(1, 4'h2, 0, 4'h4, 3));
      tab.push_back(mk(1, 4'h0, 0, 4'h4, 2));
      tab.push_back(mk(1, 4'h2, 0, 4'h4, 3));
      for (int i = 0; i < 3; i++) tab.push_back(mk(1, 4'h2, 0, 4'h4, 3));
      tab.push_back(mk(1, 4'h2, 1, 4'h2, 4));
      tab.push_back(mk(0, 4'h0, 0, 4'h2, 5));
      tab.push_back(mk(0, 4'h0, 0, 4'h2, 0));
      // held button at arm
      for (int i = 0; i < 3; i++) tab.push_back(mk(1, 4'h1, 0, 4'h2, 1));
      tab.push_back(mk(1, 4'h0, 0, 4'h2, 2));
      tab.push_back(mk(1, 4'h8, 0, 4'h2, 3));
      for (int i = 0; i < 3; i++) tab.push_back(mk(1, 4'h8, 0, 4'h2, 3));
      tab.push_back(mk(1, 4'h8, 1, 4'h8, 4));
      tab.push_back(mk(0, 4'h8, 0, 4'h8, 5));
      tab.push_back(mk(0, 4'h0, 0, 4'h8, 0));
      // multi-button, then abort mid-FILTRA
      tab.push_back(mk(1, 4'h0, 0, 4'h8, 1));
      tab.push_back(mk(1, 4'h0, 0, 4'h8, 2));
      tab.push_back(mk(1, 4'h3, 0, 4'h8, 2));
      tab.push_back(mk(1, 4'h3, 0, 4'h8, 2));
      tab.push_back(mk(1, 4'h1, 0, 4'h8, 3));
      tab.push_back(mk(1, 4'h1, 0, 4'h8, 3));
      tab.push_back(mk(0, 4'h1, 0, 4'h8, 0));

      do_reset();
      chk_reset_vals("reset_init");

      for (int i = 0; i < tab.size(); i++) begin
         step(tab[i].a, tab[i].b);
         chk($sformatf("tab%0d_jogada", i), jogada, tab[i].j);
         chk($sformatf("tab%0d_code", i), jogada_code, tab[i].c);
         chk($sformatf("tab%0d_estado", i), db_estado, tab[i].e);
         chk($sformatf("tab%0d_timeout", i), timeout, 1'b0);
      end

      // reset while filtering
      step(1, 4'h0);
      step(1, 4'h0);
      step(1, 4'h4);
      step(1, 4'h4);
      chk("pre_reset_filtra", db_estado, 4'd3);
      do_reset();
      chk_reset_vals("reset_filtra");

      // timeout, then reset while expired
      for (int i = 0; i < TO; i++) step(1, 4'h0);
      chk("before_expiry", timeout, 1'b0);
      step(1, 4'h0);
      chk("to_timeout", timeout, TO_EN);
      chk("to_estado", db_estado, TO_EN ? 4'd6 : 4'd2);
      step(1, 4'h0);
      chk("to_hold", timeout, TO_EN);
      do_reset();
      chk_reset_vals("reset_tempo");

      // timeout cleared one cycle after armar falls
      for (int i = 0; i < TO + 1; i++) step(1, 4'h0);
      chk("to2_timeout", timeout, TO_EN);
      step(0, 4'h0);
      chk("to2_drop", timeout, 1'b0);
      chk("to2_drop_estado", db_estado, 4'd0);

      // randomized run
      hold = 0;
      rb = 4'h0;
      armar = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         if (hold == 0) begin
            case ($urandom_range(0, 9))
               0, 1, 2: rb = 4'h0;
               8, 9:    rb = 4'($urandom_range(0, 15));
               default: rb = 4'(1 << $urandom_range(0, 3));
            endcase
            hold = $urandom_range(1, 7);
         end
         hold--;
         if ($urandom_range(0, 39) == 0) armar = ~armar;
         if ($urandom_range(0, 599) == 0) begin
            do_reset();
            chk_reset_vals("reset_rand");
         end else begin
            step(armar, rb);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
